// File: rtl/status_encoder_if.sv
// UART TX byte handshake between status_encoder (master) and the UART transmitter (slave).
interface status_encoder_if;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic       i_tx_done_tick;

    modport master (output o_tx_start, output o_tx_data, input i_tx_done_tick);
    modport slave  (input o_tx_start, input o_tx_data, output i_tx_done_tick);
endinterface

// File: rtl/status_encoder.sv
// Frames pattern/frequency/control state into a UART byte stream: CMD, pattern, freq (MSB byte first).
// Optional STATUS_ENC_CHECKSUM_EN appends an XOR checksum byte over all preceding frame bytes.
module status_encoder #(
    parameter int         DATA_BIT = 16,
    parameter logic [3:0] CMD_TAG  = 4'hA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_send,
    input  logic [DATA_BIT-1:0] i_output_pattern,
    input  logic [DATA_BIT-1:0] i_freq_pattern,
    input  logic                i_mode,
    input  logic                i_start,
    input  logic                i_stop,
    status_encoder_if.master    tx,
    output logic                o_busy,
    output logic                o_done_tick
);
    localparam int NB = DATA_BIT / 8;
`ifdef STATUS_ENC_CHECKSUM_EN
    localparam int FRAME_LEN = 2 + 2 * NB;
`else
    localparam int FRAME_LEN = 1 + 2 * NB;
`endif
    localparam int IDX_W = $clog2(1 + 2 * NB + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [2:0]          flags_q, flags_d;
    logic [DATA_BIT-1:0] pat_q, pat_d;
    logic [DATA_BIT-1:0] freq_q, freq_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                busy_q, busy_d;
    logic                done_tick_q, done_tick_d;

    // Byte idx of the frame; flags = {stop, start, mode}.
    function automatic logic [7:0] frame_byte(
        input logic [IDX_W-1:0]    idx,
        input logic [2:0]          flags,
        input logic [DATA_BIT-1:0] pat,
        input logic [DATA_BIT-1:0] freq
    );
        logic [7:0] b;
`ifdef STATUS_ENC_CHECKSUM_EN
        logic [7:0] chk;
        chk = {CMD_TAG, 1'b0, flags};
`endif
        b = {CMD_TAG, 1'b0, flags};
        for (int k = 0; k < NB; k++) begin
            if (idx == IDX_W'(1 + k))      b = pat[(NB-1-k)*8 +: 8];
            if (idx == IDX_W'(1 + NB + k)) b = freq[(NB-1-k)*8 +: 8];
`ifdef STATUS_ENC_CHECKSUM_EN
            chk = chk ^ pat[(NB-1-k)*8 +: 8] ^ freq[(NB-1-k)*8 +: 8];
`endif
        end
`ifdef STATUS_ENC_CHECKSUM_EN
        if (idx == IDX_W'(1 + 2 * NB)) b = chk;
`endif
        return b;
    endfunction

    // Outputs are registered: tx_start/tx_data are set on the edge entering LOAD,
    // so the byte for the next state is computed here one cycle ahead.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        flags_d     = flags_q;
        pat_d       = pat_q;
        freq_d      = freq_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        busy_d      = busy_q;
        done_tick_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_send) begin
                    flags_d    = {i_stop, i_start, i_mode};
                    pat_d      = i_output_pattern;
                    freq_d     = i_freq_pattern;
                    idx_d      = '0;
                    state_d    = S_LOAD;
                    tx_start_d = 1'b1;
                    tx_data_d  = frame_byte(IDX_W'(0), {i_stop, i_start, i_mode},
                                            i_output_pattern, i_freq_pattern);
                    busy_d     = 1'b1;
                end
            end
            S_LOAD: state_d = S_WAIT;
            S_WAIT: begin
                if (tx.i_tx_done_tick) begin
                    if (idx_q == LAST_IDX) begin
                        state_d     = S_DONE;
                        done_tick_d = 1'b1;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        state_d    = S_LOAD;
                        tx_start_d = 1'b1;
                        tx_data_d  = frame_byte(idx_q + IDX_W'(1), flags_q, pat_q, freq_q);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            flags_q     <= '0;
            pat_q       <= '0;
            freq_q      <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            busy_q      <= 1'b0;
            done_tick_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            flags_q     <= flags_d;
            pat_q       <= pat_d;
            freq_q      <= freq_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            done_tick_q <= done_tick_d;
        end
    end

    assign tx.o_tx_start = tx_start_q;
    assign tx.o_tx_data  = tx_data_q;
    assign o_busy        = busy_q;
    assign o_done_tick   = done_tick_q;
endmodule
